// File: rtl/adder_tile_scheduler.sv
// Tile sequencer for the ternary adder-tree datapath: issues a job's tiles, accumulates the
// returned tree sums and hands the total to the scaler stage over a valid/ready port.
module adder_tile_scheduler #(
  parameter int unsigned FEATURE_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned TILE_CNT_WIDTH = 8
) (
  input  logic                      fast_clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_tiles,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      tree_enable,
  input  logic                      tree_done,
  input  logic [FEATURE_WIDTH-1:0]  tree_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      busy,
  output logic                      err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;
  localparam logic [1:0] StOutput = 2'd3;

  localparam logic [TILE_CNT_WIDTH-1:0] TileOne = TILE_CNT_WIDTH'(1);

  logic [1:0]                state_q, state_d;
  logic [TILE_CNT_WIDTH-1:0] tiles_q, tiles_d;
  logic [TILE_CNT_WIDTH-1:0] issued_q, issued_d;
  logic [TILE_CNT_WIDTH-1:0] returned_q, returned_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic                      err_q, err_d;

  logic                      accumulating;
  logic                      in_flight;
  logic                      done_ok;
  logic                      done_bad;
  logic                      last_issue;
  logic [TILE_CNT_WIDTH-1:0] returned_inc;
  logic [ACC_WIDTH-1:0]      sum_ext;

  assign cfg_ready   = (state_q == StIdle);
  assign in_ready    = (state_q == StIssue);
  assign tree_enable = in_valid & in_ready;
  assign out_valid   = (state_q == StOutput);
  assign out_data    = out_valid ? acc_q : '0;
  assign busy        = (state_q != StIdle);
  assign err         = err_q;

  // A strobe is only legitimate while some issued tile has not yet come back.
  assign accumulating = (state_q == StIssue) || (state_q == StDrain);
  assign in_flight    = (issued_q != returned_q);
  assign done_ok      = tree_done & accumulating & in_flight;
  assign done_bad     = tree_done & ~done_ok;

  assign last_issue   = (issued_q == (tiles_q - TileOne));
  assign returned_inc = returned_q + TileOne;
  assign sum_ext      = ACC_WIDTH'($signed(tree_sum));

  always_comb begin
    state_d    = state_q;
    tiles_d    = tiles_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    acc_d      = acc_q;
    err_d      = err_q;

    if (done_ok) begin
      acc_d      = acc_q + sum_ext;
      returned_d = returned_inc;
    end
    if (done_bad) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          tiles_d    = (cfg_tiles == '0) ? TileOne : cfg_tiles;
          issued_d   = '0;
          returned_d = '0;
          acc_d      = '0;
          // A stray strobe on the accept cycle is still reported for the new job.
          err_d      = done_bad;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (tree_enable) begin
          issued_d = issued_q + TileOne;
          if (last_issue) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (done_ok && (returned_inc == tiles_q)) begin
          state_d = StOutput;
        end
      end
      StOutput: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tiles_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tiles_q    <= tiles_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_adder_tile_scheduler.sv
// Directed bench for adder_tile_scheduler: a 5-cycle tree model on the default instance plus a
// narrow 8-bit instance driven by hand for the accumulator wrap case.
module tb_adder_tile_scheduler;

  logic        fast_clk = 1'b0;
  logic        rst;

  logic        cfg_valid, cfg_ready, in_valid, in_ready, tree_enable, tree_done;
  logic [7:0]  cfg_tiles;
  logic [15:0] tree_sum;
  logic        out_valid, out_ready, busy, err;
  logic [31:0] out_data;

  logic        n_cfg_valid, n_cfg_ready, n_in_valid, n_in_ready, n_tree_enable, n_tree_done;
  logic [7:0]  n_cfg_tiles, n_tree_sum, n_out_data;
  logic        n_out_valid, n_out_ready, n_busy, n_err;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;
  int en_base;

  logic [15:0] sum_q [$];
  logic [4:0]  pv = '0;
  logic [15:0] pd [5] = '{default: '0};
  logic        stray_done = 1'b0;
  logic [15:0] stray_sum  = '0;

  always #5 fast_clk = ~fast_clk;

  adder_tile_scheduler #(
    .FEATURE_WIDTH (16),
    .ACC_WIDTH     (32),
    .TILE_CNT_WIDTH(8)
  ) u_dut (
    .fast_clk   (fast_clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_tiles  (cfg_tiles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tree_enable(tree_enable),
    .tree_done  (tree_done),
    .tree_sum   (tree_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err)
  );

  adder_tile_scheduler #(
    .FEATURE_WIDTH (8),
    .ACC_WIDTH     (8),
    .TILE_CNT_WIDTH(8)
  ) u_dut_narrow (
    .fast_clk   (fast_clk),
    .rst        (rst),
    .cfg_valid  (n_cfg_valid),
    .cfg_ready  (n_cfg_ready),
    .cfg_tiles  (n_cfg_tiles),
    .in_valid   (n_in_valid),
    .in_ready   (n_in_ready),
    .tree_enable(n_tree_enable),
    .tree_done  (n_tree_done),
    .tree_sum   (n_tree_sum),
    .out_valid  (n_out_valid),
    .out_ready  (n_out_ready),
    .out_data   (n_out_data),
    .busy       (n_busy),
    .err        (n_err)
  );

  // Tree model: not reset by rst, so in-flight strobes survive a mid-job reset.
  always @(posedge fast_clk) begin
    logic [15:0] s;
    s = '0;
    if (tree_enable && (sum_q.size() > 0)) s = sum_q.pop_front();
    pv    <= {pv[3:0], tree_enable};
    pd[0] <= s;
    for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
    if (tree_enable) en_cnt <= en_cnt + 1;
  end

  assign tree_done = pv[4] | stray_done;
  assign tree_sum  = stray_done ? stray_sum : pd[4];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] n);
    cfg_valid = 1'b1;
    cfg_tiles = n;
    @(negedge fast_clk);
    cfg_valid = 1'b0;
    #1 check_eq("accept in_ready", in_ready, 1'b1);
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge fast_clk);
      k++;
    end
    check_eq("out_valid timeout", out_valid, 1'b1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge fast_clk);
    out_ready = 1'b0;
    #1 check_eq("release idle", cfg_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    cfg_valid = 1'b0; cfg_tiles = '0; in_valid = 1'b0; out_ready = 1'b0;
    n_cfg_valid = 1'b0; n_cfg_tiles = '0; n_in_valid = 1'b0; n_out_ready = 1'b0;
    n_tree_done = 1'b0; n_tree_sum = '0;

    // Reset
    repeat (3) @(negedge fast_clk);
    #1;
    check_eq("rst cfg_ready", cfg_ready, 1'b1);
    check_eq("rst in_ready", in_ready, 1'b0);
    check_eq("rst tree_enable", tree_enable, 1'b0);
    check_eq("rst out_valid", out_valid, 1'b0);
    check_eq("rst out_data", out_data, 32'd0);
    check_eq("rst busy", busy, 1'b0);
    check_eq("rst err", err, 1'b0);
    rst = 1'b1;
    @(negedge fast_clk);
    #1 check_eq("post-rst cfg_ready", cfg_ready, 1'b1);

    // Basic job: 10 + 20 - 5 = 25, exact latency
    sum_q.push_back(16'd10); sum_q.push_back(16'd20); sum_q.push_back(16'hFFFB);
    start_job(8'd3);
    check_eq("basic busy", busy, 1'b1);
    check_eq("basic cfg_ready", cfg_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      #1 check_eq("basic enable", tree_enable, 1'b1);
      @(negedge fast_clk);
    end
    in_valid = 1'b0;
    #1 check_eq("basic drain in_ready", in_ready, 1'b0);
    repeat (4) @(negedge fast_clk);
    check_eq("basic not early", out_valid, 1'b0);
    @(negedge fast_clk);
    check_eq("basic out_valid T+6", out_valid, 1'b1);
    check_eq("basic out_data", out_data, 32'd25);
    release_out();
    check_eq("basic out_valid drop", out_valid, 1'b0);
    @(negedge fast_clk);
    check_eq("basic cfg_ready T+8", cfg_ready, 1'b1);

    // Backpressure: gapped issue, stalled output
    sum_q.push_back(16'd1); sum_q.push_back(16'd2); sum_q.push_back(16'd3);
    start_job(8'd3);
    en_base = en_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge fast_clk);
    end
    in_valid = 1'b0;
    wait_out();
    check_eq("bp out_data", out_data, 32'd6);
    check_eq("bp enable count", 64'(en_cnt - en_base), 64'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge fast_clk);
      check_eq("bp stall out_data", out_data, 32'd6);
      check_eq("bp stall out_valid", out_valid, 1'b1);
      check_eq("bp stall in_ready", in_ready, 1'b0);
      check_eq("bp stall cfg_ready", cfg_ready, 1'b0);
    end
    release_out();

    // Zero tile count issues one tile
    sum_q.push_back(16'd7);
    start_job(8'd0);
    en_base = en_cnt;
    in_valid = 1'b1;
    repeat (3) @(negedge fast_clk);
    in_valid = 1'b0;
    wait_out();
    check_eq("zero enable count", 64'(en_cnt - en_base), 64'd1);
    check_eq("zero out_data", out_data, 32'd7);
    release_out();

    // Stray done in IDLE
    stray_sum  = 16'd9;
    stray_done = 1'b1;
    @(negedge fast_clk);
    stray_done = 1'b0;
    #1;
    check_eq("stray err", err, 1'b1);
    check_eq("stray busy", busy, 1'b0);
    check_eq("stray out_data", out_data, 32'd0);
    sum_q.push_back(16'd5);
    start_job(8'd1);
    check_eq("stray err cleared", err, 1'b0);
    in_valid = 1'b1;
    @(negedge fast_clk);
    in_valid = 1'b0;
    wait_out();
    check_eq("stray next sum", out_data, 32'd5);
    release_out();

    // Reset during DRAIN of a 4-tile job
    for (int i = 0; i < 4; i++) sum_q.push_back(16'd1);
    start_job(8'd4);
    in_valid = 1'b1;
    repeat (4) @(negedge fast_clk);
    in_valid = 1'b0;
    @(negedge fast_clk);
    rst = 1'b0;
    #1;
    check_eq("midrst busy", busy, 1'b0);
    check_eq("midrst cfg_ready", cfg_ready, 1'b1);
    check_eq("midrst in_ready", in_ready, 1'b0);
    check_eq("midrst out_valid", out_valid, 1'b0);
    check_eq("midrst err", err, 1'b0);
    @(negedge fast_clk);
    rst = 1'b1;
    repeat (6) @(negedge fast_clk);
    check_eq("midrst stale err", err, 1'b1);
    sum_q.push_back(16'd3); sum_q.push_back(16'd4);
    start_job(8'd2);
    check_eq("midrst err cleared", err, 1'b0);
    in_valid = 1'b1;
    repeat (2) @(negedge fast_clk);
    in_valid = 1'b0;
    wait_out();
    check_eq("midrst new sum", out_data, 32'd7);
    check_eq("midrst new err", err, 1'b0);
    release_out();

    // Narrow instance: 100 + 100 wraps to 8'hC8
    n_cfg_valid = 1'b1;
    n_cfg_tiles = 8'd2;
    @(negedge fast_clk);
    n_cfg_valid = 1'b0;
    n_in_valid  = 1'b1;
    #1 check_eq("wrap enable", n_tree_enable, 1'b1);
    repeat (2) @(negedge fast_clk);
    n_in_valid  = 1'b0;
    n_tree_done = 1'b1;
    n_tree_sum  = 8'd100;
    repeat (2) @(negedge fast_clk);
    n_tree_done = 1'b0;
    #1;
    check_eq("wrap out_valid", n_out_valid, 1'b1);
    check_eq("wrap out_data", n_out_data, 8'hC8);
    check_eq("wrap err", n_err, 1'b0);
    n_out_ready = 1'b1;
    @(negedge fast_clk);
    n_out_ready = 1'b0;
    #1 check_eq("wrap idle", n_cfg_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
